// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared types and constants for the 80x30 text renderer.
// Holds the CGA palette, text-cell layout and pipeline geometry.
package vga_text_pkg;

    localparam int CHAR_W     = 8;
    localparam int CHAR_H     = 16;
    localparam int PIPE_DEPTH = 4;
    localparam int PX_W       = $clog2(CHAR_W);
    localparam int LINE_W     = $clog2(CHAR_H);

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // Text RAM word: {blink, bg[2:0], fg[3:0], char[7:0]}
    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    typedef struct packed {
        attr_t      attr;
        logic [7:0] ch;
    } cell_t;

    typedef struct packed {
        logic [PX_W-1:0] px;
        logic            de;
        logic            hs;
        logic            vs;
    } sb_t;

    localparam sb_t SB_RST = '{
        px: '0,
        de: 1'b0,
        hs: 1'b1,
        vs: 1'b1
    };

    function automatic logic [11:0] pal(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_text_render_font_rom.sv
// font_rom: 4096x8 synchronous glyph ROM, address {char, line}, 1-cycle read.
// Built-in table: 'A', '/', shade 0xB1 and block 0xDB; other codes are blank.
module font_rom
    import vga_text_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    localparam logic [7:0] GLYPH_A [CHAR_H] = '{
        8'h18, 8'h3C, 8'h66, 8'h66,
        8'hC3, 8'hC3, 8'hFF, 8'hFF,
        8'hC3, 8'hC3, 8'hC3, 8'hC3,
        8'hC3, 8'h00, 8'h00, 8'h00
    };

    logic [7:0]        w_ch;
    logic [LINE_W-1:0] w_line;
    logic [7:0]        w_row;
    logic [7:0]        r_data;

    assign w_ch   = i_addr[11:4];
    assign w_line = i_addr[3:0];

    always_comb begin
        w_row = 8'h00;
        case (w_ch)
            8'h41:   w_row = GLYPH_A[w_line];
            8'h2F:   w_row = 8'h01 << w_line[3:1];
            8'hB1:   w_row = w_line[0] ? 8'h55 : 8'hAA;
            8'hDB:   w_row = 8'hFF;
            default: w_row = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= 8'h00;
        end else begin
            r_data <= w_row;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 text pixel pipeline, rgb 4 cycles after posx/posy.
// Optional blinking underline cursor when VGA_TEXT_CURSOR_EN is defined.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int ADDR_W    = 12,
    parameter int BLINK_BIT = 5
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [9:0]        posx,
    input  logic [9:0]        posy,
    input  logic              de,
    input  logic              hsync,
    input  logic              vsync,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [15:0]       vram_data,
    input  logic [6:0]        cursor_x,
    input  logic [4:0]        cursor_y,
    output logic [11:0]       rgb,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o
);

    // Row scaling below is hard-wired as (row<<6)+(row<<4).
    if ((COLS != 80) || (COLS * ROWS > (1 << ADDR_W))
        || (BLINK_BIT > 5)) begin : g_bad_cfg
        $error("vga_text_render: unsupported configuration");
    end

    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_vram_addr;

    sb_t               r_sb [PIPE_DEPTH];
    sb_t               w_sb_in;
    sb_t               w_sb_last;
    logic [LINE_W-1:0] r_line0;
    logic [LINE_W-1:0] r_line1;

    cell_t             w_cell;
    logic [11:0]       r_font_addr;
    attr_t             r_attr2;
    attr_t             r_attr3;
    logic [7:0]        w_rom_q;
    logic [7:0]        w_glyph;

    logic              r_vs_d;
    logic [5:0]        r_frame_cnt;

    logic [3:0]        w_fg;
    logic [3:0]        w_bg;
    logic              w_bit;
    logic [3:0]        w_idx;
    logic [11:0]       r_rgb;
    logic              r_hs;
    logic              r_vs;
    logic              r_de;
    logic              w_unused_posy;

    assign w_unused_posy = posy[9];

    assign w_row  = ADDR_W'(posy[8:4]);
    assign w_col  = ADDR_W'(posx[9:3]);
    assign w_addr = (w_row << 6) + (w_row << 4) + w_col;

    assign w_sb_in = '{
        px: posx[2:0],
        de: de,
        hs: hsync,
        vs: vsync
    };

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_vram_addr <= '0;
            r_line0     <= '0;
            r_line1     <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sb[i] <= SB_RST;
            end
        end else begin
            r_vram_addr <= w_addr;
            r_line0     <= posy[3:0];
            r_line1     <= r_line0;
            r_sb[0]     <= w_sb_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    assign vram_addr = r_vram_addr;
    assign w_cell    = cell_t'(vram_data);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_font_addr <= '0;
            r_attr2     <= '0;
            r_attr3     <= '0;
        end else begin
            r_font_addr <= {w_cell.ch, r_line1};
            r_attr2     <= w_cell.attr;
            r_attr3     <= r_attr2;
        end
    end

    font_rom u_font (
        .i_clk  (vga_clk),
        .i_rst  (rst),
        .i_addr (r_font_addr),
        .o_data (w_rom_q)
    );

    // Frame counter advances on each vsync falling edge.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_vs_d      <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_vs_d <= vsync;
            if (r_vs_d && !vsync) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [PIPE_DEPTH-1:0] r_cur;
    logic                  w_cur_hit;

    // Underline occupies glyph lines 14 and 15 of the cursor cell.
    assign w_cur_hit = (posx[9:3] == cursor_x)
                    && (posy[8:4] == cursor_y)
                    && (posy[3:1] == 3'b111);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_cur <= '0;
        end else begin
            r_cur <= {r_cur[PIPE_DEPTH-2:0], w_cur_hit};
        end
    end

    assign w_glyph = (r_cur[PIPE_DEPTH-1] && r_frame_cnt[4])
                   ? 8'hFF : w_rom_q;
`else
    logic w_unused_cursor;

    assign w_unused_cursor = ^{cursor_x, cursor_y};
    assign w_glyph         = w_rom_q;
`endif

    assign w_sb_last = r_sb[PIPE_DEPTH-1];
    assign w_bg      = {1'b0, r_attr3.bg};
    assign w_fg      = (r_attr3.blink && r_frame_cnt[BLINK_BIT])
                     ? w_bg : r_attr3.fg;
    assign w_bit     = w_glyph[3'(CHAR_W - 1) - w_sb_last.px];
    assign w_idx     = w_bit ? w_fg : w_bg;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_rgb <= 12'h000;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
        end else begin
            r_rgb <= w_sb_last.de ? pal(w_idx) : 12'h000;
            r_hs  <= w_sb_last.hs;
            r_vs  <= w_sb_last.vs;
            r_de  <= w_sb_last.de;
        end
    end

    assign rgb     = r_rgb;
    assign hsync_o = r_hs;
    assign vsync_o = r_vs;
    assign de_o    = r_de;

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: table-driven and randomized checks of vga_text_render
// against a pixel-level reference model of the text mode.
`timescale 1ns/1ps
module tb_vga_text_render;

    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    localparam logic [7:0] A_ROWS [16] = '{
        8'h18, 8'h3C, 8'h66, 8'h66, 8'hC3, 8'hC3, 8'hFF, 8'hFF,
        8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00
    };

    localparam int LAT = 4;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } out_t;

    typedef struct {
        int x;
        int y;
        int a;
    } addr_vec_t;

    localparam out_t IDLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0};
    localparam out_t VSLO = '{rgb: 12'h000, hs: 1'b1, vs: 1'b0, de: 1'b0};
    localparam out_t HSLO = '{rgb: 12'h000, hs: 1'b0, vs: 1'b1, de: 1'b0};

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  posx;
    logic [9:0]  posy;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] rgb;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;

    logic [15:0] mem [4096];

    out_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fc = 0;
    logic        prev_vs = 1'b1;
    logic        last_hso = 1'b1;
    int          hso_fall = -1;
    int          hso_rise = -1;
    string       phase = "init";

    addr_vec_t   av [7];
    logic [11:0] gl_exp [8];

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) vram_data <= mem[vram_addr];

    vga_text_render dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .posx      (posx),
        .posy      (posy),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .rgb       (rgb),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .de_o      (de_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cycle %0d: got %0h, want %0h",
                     phase, name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] font(input logic [7:0] c, input int l);
        case (c)
            8'h41:   return A_ROWS[l];
            8'h2F:   return 8'(1 << (l / 2));
            8'hB1:   return (l % 2 == 1) ? 8'h55 : 8'hAA;
            8'hDB:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic out_t pix(input logic [11:0] c);
        out_t o;
        o.rgb = c;
        o.hs  = 1'b1;
        o.vs  = 1'b1;
        o.de  = 1'b1;
        return o;
    endfunction

    // Screen model: cell lookup, glyph bit, blink, palette, de gating.
    function automatic out_t model(input int x, input int y, input logic d,
                                   input logic h, input logic v);
        out_t        o;
        logic [15:0] w;
        logic [7:0]  g;
        logic        on;
        int          fg;
        int          bg;
        w  = mem[(y / 16) * 80 + x / 8];
        g  = font(w[7:0], y % 16);
        on = g[7 - x % 8];
        fg = int'(w[11:8]);
        bg = int'(w[14:12]);
        if (w[15] && fc >= 32) fg = bg;
        o.rgb = d ? PAL[on ? fg : bg] : 12'h000;
        o.hs  = h;
        o.vs  = v;
        o.de  = d;
        return o;
    endfunction

    function automatic logic [15:0] rand_cell();
        logic [7:0] ch;
        case ($urandom_range(0, 5))
            0:       ch = 8'h41;
            1:       ch = 8'h2F;
            2:       ch = 8'hB1;
            3:       ch = 8'hDB;
            4:       ch = 8'h20;
            default: ch = 8'($urandom);
        endcase
        return {8'($urandom), ch};
    endfunction

    task automatic tick(input int x, input int y, input logic d,
                        input logic h, input logic v, input out_t e);
        out_t f;
        posx  = 10'(x);
        posy  = 10'(y);
        de    = d;
        hsync = h;
        vsync = v;
        if (prev_vs && !v) fc = (fc + 1) % 64;
        prev_vs = v;
        q.push_back(e);
        @(posedge vga_clk);
        #1;
        cyc++;
        if (q.size() > LAT) begin
            f = q.pop_front();
            check("rgb", 32'(rgb), 32'(f.rgb));
            check("hsync_o", 32'(hsync_o), 32'(f.hs));
            check("vsync_o", 32'(vsync_o), 32'(f.vs));
            check("de_o", 32'(de_o), 32'(f.de));
        end
        if (last_hso && !hsync_o) hso_fall = cyc;
        if (!last_hso && hsync_o) hso_rise = cyc;
        last_hso = hsync_o;
    endtask

    task automatic mtick(input int x, input int y, input logic d,
                         input logic h, input logic v);
        tick(x, y, d, h, v, model(x, y, d, h, v));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(639, 479, 1'b0, 1'b1, 1'b1, IDLE);
    endtask

    task automatic frame_pulse();
        idle(4);
        tick(639, 479, 1'b0, 1'b1, 1'b0, VSLO);
        tick(639, 479, 1'b0, 1'b1, 1'b0, VSLO);
        idle(3);
    endtask

    task automatic restart_model();
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back(IDLE);
        fc       = 0;
        prev_vs  = 1'b1;
        last_hso = 1'b1;
    endtask

    task automatic check_reset();
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync_o", 32'(hsync_o), 32'h1);
        check("rst_vsync_o", 32'(vsync_o), 32'h1);
        check("rst_de_o", 32'(de_o), 32'h0);
        check("rst_vram_addr", 32'(vram_addr), 32'h0);
    endtask

    initial begin
        int   c0;
        logic on;
        logic [7:0] g;

        av[0] = '{x: 8,   y: 16,  a: 81};
        av[1] = '{x: 639, y: 479, a: 2399};
        av[2] = '{x: 0,   y: 0,   a: 0};
        av[3] = '{x: 7,   y: 15,  a: 0};
        av[4] = '{x: 639, y: 0,   a: 79};
        av[5] = '{x: 0,   y: 479, a: 2320};
        av[6] = '{x: 320, y: 240, a: 1240};
        gl_exp = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                   12'hFFF, 12'h000, 12'h000, 12'h000};

        for (int i = 0; i < 4096; i++) mem[i] = rand_cell();
        mem[0] = 16'h0F41;

        phase = "reset";
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            posx     = 10'($urandom);
            posy     = 10'($urandom);
            de       = 1'($urandom);
            hsync    = 1'($urandom);
            vsync    = 1'($urandom);
            cursor_x = 7'($urandom);
            cursor_y = 5'($urandom);
            @(posedge vga_clk);
            #1;
            cyc++;
            check_reset();
        end
        cursor_x = 7'd127;
        cursor_y = 5'd31;
        rst = 1'b0;
        restart_model();

        phase = "addr";
        for (int i = 0; i < 7; i++) begin
            tick(av[i].x, av[i].y, 1'b0, 1'b1, 1'b1, IDLE);
            check("vram_addr", 32'(vram_addr), 32'(av[i].a));
        end

        phase = "glyph";
        for (int i = 0; i < 8; i++) begin
            tick(i, 0, 1'b1, 1'b1, 1'b1, pix(gl_exp[i]));
        end
        idle(LAT);

        phase = "sync";
        idle(4);
        c0 = cyc + 1;
        for (int i = 0; i < 96; i++) begin
            tick(639, $urandom_range(0, 479), 1'b0, 1'b0, 1'b1, HSLO);
        end
        idle(6);
        check("hs_start", 32'(hso_fall - c0), 32'(LAT));
        check("hs_width", 32'(hso_rise - hso_fall), 32'd96);

        phase = "blink";
        mem[0] = 16'h8F41;
        mem[1] = 16'hAC41;
        for (int f = 0; f < 70; f++) begin
            tick(3, 0, 1'b1, 1'b1, 1'b1,
                 pix(((f % 64) < 32) ? 12'hFFF : 12'h000));
            tick(11, 0, 1'b1, 1'b1, 1'b1,
                 pix(((f % 64) < 32) ? 12'hF55 : 12'h0A0));
            frame_pulse();
        end

        phase = "cursor";
        for (int i = 0; i < 64 && fc != 16; i++) frame_pulse();
        check("fc_model", 32'(fc), 32'd16);
        mem[82]  = 16'h0F41;
        cursor_x = 7'd2;
        cursor_y = 5'd1;
        for (int y = 29; y < 32; y++) begin
            for (int x = 16; x < 24; x++) begin
                g  = font(8'h41, y % 16);
                on = g[7 - x % 8];
`ifdef VGA_TEXT_CURSOR_EN
                if (y >= 30) on = 1'b1;
`endif
                tick(x, y, 1'b1, 1'b1, 1'b1, pix(on ? 12'hFFF : 12'h000));
            end
        end
        idle(LAT);
        cursor_x = 7'd127;
        cursor_y = 5'd31;

        phase = "random";
        for (int k = 0; k < 3000; k++) begin
            if (k % 60 == 59) begin
                frame_pulse();
            end else begin
                mtick($urandom_range(0, 639), $urandom_range(0, 479),
                      ($urandom % 8) != 0, ($urandom % 4) != 0, 1'b1);
            end
        end
        idle(LAT);

        phase = "midreset";
        for (int x = 100; x < 120; x++) mtick(x, 200, 1'b1, 1'b1, 1'b1);
        posx = 10'd120;
        de   = 1'b1;
        rst  = 1'b1;
        @(posedge vga_clk);
        #1;
        cyc++;
        check_reset();
        rst = 1'b0;
        restart_model();
        for (int k = 0; k < 200; k++) begin
            mtick($urandom_range(0, 639), $urandom_range(0, 479),
                  ($urandom % 8) != 0, 1'b1, 1'b1);
        end
        idle(LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
